// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Upstream sequencer for the sequential Booth multiplier. Accepts one
//   multiply request, latches both operands, clears and starts the
//   multiplier, waits (bounded) for its done, then writes the 2W-bit product
//   into the HI/LO registers. busy stays high for the whole operation so the
//   control unit stalls.
//
//   Optional build macro: MUL_ZERO_SHORTCUT_EN
//     When defined, a request with a zero operand skips the multiplier and
//     goes straight to WRITE with HI/LO forced to zero. When undefined, every
//     request takes the full CLEAR/LAUNCH/WAIT path.
module mul_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 48
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req,
    input  logic signed [DATA_WIDTH-1:0]   op_a,
    input  logic signed [DATA_WIDTH-1:0]   op_b,
    output logic                           busy,
    output logic                           mul_clr,
    output logic                           mul_start,
    output logic signed [DATA_WIDTH-1:0]   mul_multiplicand,
    output logic signed [DATA_WIDTH-1:0]   mul_multiplier,
    input  logic                           mul_done,
    input  logic signed [2*DATA_WIDTH-1:0] mul_product,
    output logic        [DATA_WIDTH-1:0]   hi_out,
    output logic        [DATA_WIDTH-1:0]   lo_out,
    output logic                           result_valid,
    output logic                           timeout_err
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LAUNCH,
        ST_WAIT,
        ST_WRITE
    } state_t;

    state_t                        state_q, state_d;
    logic        [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic signed [DATA_WIDTH-1:0]  opa_q, opa_d;
    logic signed [DATA_WIDTH-1:0]  opb_q, opb_d;
    logic        [DATA_WIDTH-1:0]  hi_q, hi_d;
    logic        [DATA_WIDTH-1:0]  lo_q, lo_d;
    logic                          timeout_q, timeout_d;

    // Single-cycle events decoded from the current state and inputs.
    logic accept;
    logic shortcut;
    logic capture;
    logic abort;

`ifdef MUL_ZERO_SHORTCUT_EN
    function automatic logic any_zero(input logic signed [DATA_WIDTH-1:0] a,
                                      input logic signed [DATA_WIDTH-1:0] b);
        return (a == '0) || (b == '0);
    endfunction
`endif

    // Next-state selection and event decode; mul_done only matters in WAIT.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shortcut = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = ST_CLEAR;
`ifdef MUL_ZERO_SHORTCUT_EN
                    if (any_zero(op_a, op_b)) begin
                        shortcut = 1'b1;
                        state_d  = ST_WRITE;
                    end
`endif
                end
            end
            ST_CLEAR: begin
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    capture = 1'b1;
                    state_d = ST_WRITE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand latch and wait counter: operands only change on acceptance.
    always_comb begin
        opa_d      = opa_q;
        opb_d      = opb_q;
        wait_cnt_d = wait_cnt_q;
        if (accept) begin
            opa_d = op_a;
            opb_d = op_b;
        end
        if (state_q == ST_LAUNCH) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // HI/LO update: product passes through untouched; zero shortcut forces 0.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        timeout_d = abort;
        if (capture) begin
            hi_d = mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_d = mul_product[DATA_WIDTH-1:0];
        end else if (shortcut) begin
            hi_d = '0;
            lo_d = '0;
        end
    end

    // State and register update; reset returns everything to zero/IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            timeout_q  <= timeout_d;
        end
    end

    // Our reset also clears the multiplier; start and result_valid are
    // suppressed during reset so clr/start never overlap and an aborted
    // operation never reports a result.
    assign busy             = (state_q != ST_IDLE);
    assign mul_clr          = reset | (state_q == ST_CLEAR);
    assign mul_start        = ~reset & (state_q == ST_LAUNCH);
    assign result_valid     = ~reset & (state_q == ST_WRITE);
    assign timeout_err      = timeout_q;
    assign mul_multiplicand = opa_q;
    assign mul_multiplier   = opb_q;
    assign hi_out           = hi_q;
    assign lo_out           = lo_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl
//   Directed bench for mul_issue_ctrl with a behavioural multiplier, a
//   timeline model of the sequencer and literal expectations per scenario.
module tb_mul_issue_ctrl;

    localparam int W   = 32;
    localparam int TMO = 48;
`ifdef MUL_ZERO_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
    localparam int T6_RV    = 8;
    localparam int T6_ST    = 0;
`else
    localparam bit SHORTCUT = 1'b0;
    localparam int T6_RV    = 2;
    localparam int T6_ST    = 2;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  req;
    logic signed [W-1:0]   op_a;
    logic signed [W-1:0]   op_b;
    logic                  busy;
    logic                  mul_clr;
    logic                  mul_start;
    logic signed [W-1:0]   mul_multiplicand;
    logic signed [W-1:0]   mul_multiplier;
    logic                  mul_done = 1'b0;
    logic signed [2*W-1:0] mul_product = '0;
    logic [W-1:0]          hi_out;
    logic [W-1:0]          lo_out;
    logic                  result_valid;
    logic                  timeout_err;

    mul_issue_ctrl #(.DATA_WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .op_a             (op_a),
        .op_b             (op_b),
        .busy             (busy),
        .mul_clr          (mul_clr),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_done         (mul_done),
        .mul_product      (mul_product),
        .hi_out           (hi_out),
        .lo_out           (lo_out),
        .result_valid     (result_valid),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Observed events
    int rv_cnt = 0, to_cnt = 0, st_cnt = 0;
    int rv_cyc = -1, to_cyc = -1, st_cyc = -1, clr_cyc = -1;
    int rv0, to0, st0, t0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Behavioural multiplier: done is a level that only mul_clr removes.
    int                    mm_cnt = -1;
    int                    mm_lat = 35;
    bit                    mm_dead = 1'b0;
    logic signed [2*W-1:0] mm_prod = '0;
    always @(negedge clk) begin
        if (mul_clr === 1'b1) begin
            mul_done = 1'b0;
            mm_cnt   = -1;
        end else if (mul_start === 1'b1 && !mm_dead) begin
            mm_cnt  = mm_lat;
            mm_prod = longint'(mul_multiplicand) * longint'(mul_multiplier);
        end else if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) begin
                mul_done    = 1'b1;
                mul_product = mm_prod;
            end
        end
    end

    // Timeline model: 'since' = cycles since acceptance (1 = clear cycle,
    // 2 = launch cycle, 2+k = k-th wait cycle), 'writing' = result cycle.
    int                  since   = 0;
    bit                  writing = 1'b0;
    bit                  m_to    = 1'b0;
    logic [W-1:0]        m_hi = '0, m_lo = '0;
    logic signed [W-1:0] m_a = '0, m_b = '0;
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            since = 0; writing = 1'b0; m_to = 1'b0;
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
        end else begin
            m_to = 1'b0;
            if (writing) begin
                writing = 1'b0;
            end else if (since == 0) begin
                if (req) begin
                    m_a = op_a;
                    m_b = op_b;
                    if (SHORTCUT && (op_a == 0 || op_b == 0)) begin
                        writing = 1'b1; m_hi = '0; m_lo = '0;
                    end else begin
                        since = 1;
                    end
                end
            end else if (since >= 3 && mul_done) begin
                m_hi = mul_product[2*W-1:W];
                m_lo = mul_product[W-1:0];
                writing = 1'b1;
                since = 0;
            end else if (since - 2 == TMO) begin
                since = 0;
                m_to  = 1'b1;
            end else begin
                since++;
            end
        end
    end

    // Per-cycle comparison against the model, plus event recording.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   64'(busy),         64'((since != 0) || writing));
            check("clr",    64'(mul_clr),      64'(reset || since == 1));
            check("start",  64'(mul_start),    64'(!reset && since == 2));
            check("rvalid", 64'(result_valid), 64'(!reset && writing));
            check("tmo",    64'(timeout_err),  64'(m_to));
            check("mcand",  64'(mul_multiplicand), 64'(m_a));
            check("mplier", 64'(mul_multiplier),   64'(m_b));
            check("hi",     64'(hi_out),       64'(m_hi));
            check("lo",     64'(lo_out),       64'(m_lo));
            if (result_valid === 1'b1) begin rv_cnt++; rv_cyc = cyc; end
            if (timeout_err === 1'b1)  begin to_cnt++; to_cyc = cyc; end
            if (mul_start === 1'b1)    begin st_cnt++; st_cyc = cyc; end
            if (mul_clr === 1'b1 && reset === 1'b0) clr_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic mark();
        rv0 = rv_cnt; to0 = to_cnt; st0 = st_cnt;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        op_a = a; op_b = b; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, 64'(busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = 1'b0; op_a = '0; op_b = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_busy",  64'(busy),         64'(0));
        check("rst_clr",   64'(mul_clr),      64'(1));
        check("rst_start", 64'(mul_start),    64'(0));
        check("rst_rv",    64'(result_valid), 64'(0));
        check("rst_hi",    64'(hi_out),       64'(0));
        check("rst_lo",    64'(lo_out),       64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // 7 * -3
        mm_lat = 35;
        mark();
        issue(32'd7, 32'hFFFF_FFFD);
        wait_idle("t1_idle", 80);
        idle(2);
        check("t1_hi",        64'(hi_out), 64'(32'hFFFF_FFFF));
        check("t1_lo",        64'(lo_out), 64'(32'hFFFF_FFEB));
        check("t1_rv_pulses", 64'(rv_cnt - rv0), 64'(1));
        check("t1_start_lat", 64'(st_cyc - t0), 64'(1));
        check("t1_rv_lat",    64'(rv_cyc - t0), 64'(37));

        // Extreme operands
        issue(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_idle("t2a_idle", 80);
        idle(2);
        check("t2a_hi", 64'(hi_out), 64'(32'h3FFF_FFFF));
        check("t2a_lo", 64'(lo_out), 64'(32'h0000_0001));
        issue(32'h8000_0000, 32'h8000_0000);
        wait_idle("t2b_idle", 80);
        idle(2);
        check("t2b_hi", 64'(hi_out), 64'(32'h4000_0000));
        check("t2b_lo", 64'(lo_out), 64'(32'h0000_0000));

        // Multiplier never answers
        mm_dead = 1'b1;
        mark();
        issue(32'd5, 32'd6);
        wait_idle("t3_idle", 80);
        idle(2);
        check("t3_to_lat",    64'(to_cyc - t0),  64'(50));
        check("t3_to_pulses", 64'(to_cnt - to0), 64'(1));
        check("t3_rv_pulses", 64'(rv_cnt - rv0), 64'(0));
        check("t3_hi",        64'(hi_out), 64'(32'h4000_0000));
        check("t3_lo",        64'(lo_out), 64'(32'h0000_0000));
        mm_dead = 1'b0;

        // Stale done left high, then a fresh operation
        mm_lat = 35;
        issue(32'd3, 32'd5);
        wait_idle("t4a_idle", 80);
        idle(3);
        check("t4a_lo", 64'(lo_out), 64'(32'd15));
        mm_lat = 5;
        mark();
        issue(32'hFFFF_FFFE, 32'd9);
        wait_idle("t4_idle", 80);
        idle(2);
        check("t4_clr_at",   64'(clr_cyc - t0), 64'(0));
        check("t4_start_at", 64'(st_cyc - t0),  64'(1));
        check("t4_rv_at",    64'(rv_cyc - t0),  64'(7));
        check("t4_hi",       64'(hi_out), 64'(32'hFFFF_FFFF));
        check("t4_lo",       64'(lo_out), 64'(32'hFFFF_FFEE));

        // req held high with a zero operand
        mm_lat = 4;
        mark();
        op_a = 32'd9; op_b = '0; req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 8) check("t6_idle_gap", 64'(busy), 64'(0));
        end
        req = 1'b0;
        wait_idle("t6_idle", 80);
        idle(2);
        check("t6_rv_pulses",    64'(rv_cnt - rv0), 64'(T6_RV));
        check("t6_start_pulses", 64'(st_cnt - st0), 64'(T6_ST));
        check("t6_hi",           64'(hi_out), 64'(0));
        check("t6_lo",           64'(lo_out), 64'(0));

        // Reset during wait cycle 10
        mm_lat = 35;
        issue(32'd100, 32'd200);
        wait_idle("t5a_idle", 80);
        idle(2);
        check("t5a_lo", 64'(lo_out), 64'(32'h0000_4E20));
        mark();
        issue(32'd11, 32'd13);
        idle(11);
        check("t5_busy_pre", 64'(busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_busy", 64'(busy),    64'(0));
        check("t5_hi",   64'(hi_out),  64'(0));
        check("t5_lo",   64'(lo_out),  64'(0));
        check("t5_clr",  64'(mul_clr), 64'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        idle(45);
        check("t5_rv_pulses", 64'(rv_cnt - rv0), 64'(0));
        check("t5_to_pulses", 64'(to_cnt - to0), 64'(0));
        check("t5_busy_end",  64'(busy), 64'(0));

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
